aes128_iter_core: RTL and testbench

//  Iterative AES-128 encryption core with valid/ready handshakes on both sides.

---
 rtl/aes128_iter_core.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_aes128_iter_core.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core: UNROLL rounds per clock, on-the-fly key expansion, valid/ready on both sides.
// Optional per-round observation ports are enabled by defining AES_ROUND_TAP_EN.
module aes128_iter_core #(
    parameter int UNROLL        = 1,
    parameter int CLEAR_ON_IDLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] pt_i,
    input  logic [127:0] key_i,
    input  logic         abort_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] ct_o
`ifdef AES_ROUND_TAP_EN
    ,
    output logic         tap_valid_o,
    output logic [3:0]   tap_round_o,
    output logic [127:0] tap_state_o
`endif
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} fsm_t;

    localparam logic [3:0] UNROLL_W = 4'(UNROLL);
    localparam logic [3:0] LAST_RC  = 4'(11 - UNROLL);
    localparam logic       CLR      = (CLEAR_ON_IDLE != 0);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? aa : 8'h00);
            aa  = xtime(aa);
        end
        return acc;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_gen(input logic [3:0] r, input logic [127:0] k);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon(r), 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte n lives at [127-8n -: 8]; column-major, so byte n is row n%4, column n/4
    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic [3:0] r);
        logic [127:0] t;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                t[127 - 8 * (4 * c + rw) -: 8] = sbox(s[127 - 8 * (4 * ((c + rw) % 4) + rw) -: 8]);
            end
        end
        if (r != 4'd10) begin
            for (int c = 0; c < 4; c++) begin
                t[127 - 32 * c -: 32] = mix_col(t[127 - 32 * c -: 32]);
            end
        end
        return t ^ rk;
    endfunction

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, state_d, rkey_q, rkey_d, ct_q, ct_d;
    logic [3:0]   rc_q, rc_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] st_last_s, rk_last_s;
    logic         accept_s, last_s, go_idle_s;

    assign in_ready_o  = rst_n & ((fsm_q == S_IDLE) | ((fsm_q == S_DONE) & out_ready_i));
    assign accept_s    = in_valid_i & in_ready_o & ~abort_i;
    assign last_s      = (rc_q == LAST_RC);
    assign out_valid_o = out_valid_q;
    assign ct_o        = ct_q;

    // Unrolled round chain: rounds rc..rc+UNROLL-1 applied this cycle
    always_comb begin
        logic [127:0] st, rk;
        st = state_q;
        rk = rkey_q;
        for (int u = 0; u < UNROLL; u++) begin
            rk = key_gen(rc_q + 4'(u), rk);
            st = enc_round(st, rk, rc_q + 4'(u));
        end
        st_last_s = st;
        rk_last_s = rk;
    end

    // Next-state and datapath register updates
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rkey_d      = rkey_q;
        rc_d        = rc_q;
        ct_d        = ct_q;
        out_valid_d = out_valid_q;
        go_idle_s   = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (accept_s) begin
                    fsm_d   = S_BUSY;
                    state_d = pt_i ^ key_i;
                    rkey_d  = key_i;
                    rc_d    = 4'd1;
                end else begin
                    fsm_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (abort_i) begin
                    fsm_d     = S_IDLE;
                    rc_d      = 4'd0;
                    go_idle_s = 1'b1;
                end else if (last_s) begin
                    fsm_d       = S_DONE;
                    state_d     = st_last_s;
                    rkey_d      = rk_last_s;
                    rc_d        = 4'd0;
                    ct_d        = st_last_s;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = st_last_s;
                    rkey_d  = rk_last_s;
                    rc_d    = rc_q + UNROLL_W;
                end
            end
            S_DONE: begin
                if (abort_i) begin
                    fsm_d       = S_IDLE;
                    out_valid_d = 1'b0;
                    ct_d        = 128'd0;
                    go_idle_s   = 1'b1;
                end else if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    if (accept_s) begin
                        fsm_d   = S_BUSY;
                        state_d = pt_i ^ key_i;
                        rkey_d  = key_i;
                        rc_d    = 4'd1;
                    end else begin
                        fsm_d     = S_IDLE;
                        go_idle_s = 1'b1;
                    end
                end else begin
                    fsm_d = S_DONE;
                end
            end
            default: begin
                fsm_d       = S_IDLE;
                out_valid_d = 1'b0;
                rc_d        = 4'd0;
                go_idle_s   = 1'b1;
            end
        endcase
        state_d = (go_idle_s && CLR) ? 128'd0 : state_d;
        rkey_d  = (go_idle_s && CLR) ? 128'd0 : rkey_d;
        ct_d    = (go_idle_s && CLR) ? 128'd0 : ct_d;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= 128'd0;
            rkey_q      <= 128'd0;
            rc_q        <= 4'd0;
            ct_q        <= 128'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rkey_q      <= rkey_d;
            rc_q        <= rc_d;
            ct_q        <= ct_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef AES_ROUND_TAP_EN
    logic         tap_valid_q;
    logic [3:0]   tap_round_q;
    logic [127:0] tap_state_q;
    logic         tap_fire_s;

    assign tap_fire_s  = (fsm_q == S_BUSY) & ~abort_i;
    assign tap_valid_o = tap_valid_q;
    assign tap_round_o = tap_round_q;
    assign tap_state_o = tap_state_q;

    // Per-round observation registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_valid_q <= 1'b0;
            tap_round_q <= 4'd0;
            tap_state_q <= 128'd0;
        end else begin
            tap_valid_q <= tap_fire_s;
            tap_round_q <= tap_fire_s ? (rc_q + UNROLL_W - 4'd1) : tap_round_q;
            tap_state_q <= tap_fire_s ? st_last_s : tap_state_q;
        end
    end
`endif

    aes128_iter_core_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .busy_i (fsm_q == S_BUSY),
        .rc_i   (rc_q)
    );

endmodule

// Round counter range checker for aes128_iter_core.
module aes128_iter_core_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       busy_i,
    input logic [3:0] rc_i
);
    a_rc_range: assert property (@(posedge clk) disable iff (!rst_n)
                                 busy_i |-> (rc_i >= 4'd1 && rc_i <= 4'd10));
endmodule

// File: tb/tb_aes128_iter_core.sv
// Self-checking bench for aes128_iter_core: known-answer vectors on UNROLL=1,2,5,10 plus
// back-pressure, back-to-back, abort, async reset and (with AES_ROUND_TAP_EN) round-tap sequences.
module tb_aes128_iter_core;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid [4];
    logic         abort_in [4];
    logic         out_ready[4];
    logic         in_ready [4];
    logic         out_valid[4];
    logic [127:0] pt       [4];
    logic [127:0] key      [4];
    logic [127:0] ct       [4];
`ifdef AES_ROUND_TAP_EN
    logic         tap_valid[4];
    logic [3:0]   tap_round[4];
    logic [127:0] tap_state[4];
`endif

    for (genvar g = 0; g < 4; g++) begin : g_dut
        aes128_iter_core #(
            .UNROLL        (g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10),
            .CLEAR_ON_IDLE (1)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .pt_i        (pt[g]),
            .key_i       (key[g]),
            .abort_i     (abort_in[g]),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .ct_o        (ct[g])
`ifdef AES_ROUND_TAP_EN
            ,
            .tap_valid_o (tap_valid[g]),
            .tap_round_o (tap_round[g]),
            .tap_state_o (tap_state[g])
`endif
        );
    end

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs[4];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unr(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 5 : 10;
    endfunction

    task automatic wait_ov(input int k, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid[k] && lat < 40);
    endtask

    // Accept with in_valid=1, scramble inputs afterwards, check latency and ct, then hand off.
    task automatic run_vec(input int k, input logic [127:0] kk, input logic [127:0] p,
                           input logic [127:0] e, input int exp_lat, input string tag);
        int lat;
        out_ready[k] = 1'b1;
        key[k] = kk;
        pt[k] = p;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        key[k] = ~kk;
        pt[k] = ~p;
        wait_ov(k, lat);
        chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, " ct"}, ct[k], e);
        @(posedge clk); #1;
    endtask

    initial begin
        int   lat;
        logic seen;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid[k] = 1'b0; abort_in[k] = 1'b0; out_ready[k] = 1'b0;
            pt[k] = 128'd0; key[k] = 128'd0;
        end
        vecs[0] = '{KEY_B, PT_B, CT_B};
        vecs[1] = '{KEY_C, PT_C, CT_C};
        vecs[2] = '{128'd0, 128'd0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[3] = '{KEY_B, 128'h6bc1bee22e409f96e93d7e117393172a,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97};

        repeat (2) @(posedge clk); #1;
        chk("reset in_ready", in_ready[0], 128'd0);
        chk("reset out_valid", out_valid[0], 128'd0);
        chk("reset ct", ct[0], 128'd0);
        rst_n = 1'b1; #1;
        chk("post-reset in_ready", in_ready[0], 128'd1);

        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 4; k++) begin
                run_vec(k, vecs[v].key, vecs[v].pt, vecs[v].ct, 10 / unr(k),
                        $sformatf("vec%0d u%0d", v, unr(k)));
            end
        end

        // Back-pressure for 20 cycles, then same-edge handoff into the next block
        out_ready[0] = 1'b0; key[0] = KEY_B; pt[0] = PT_B; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        wait_ov(0, lat);
        chk("bp latency", 128'(lat), 128'd10);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp ct stable", ct[0], CT_B);
            chk("bp out_valid held", out_valid[0], 128'd1);
            chk("bp in_ready low", in_ready[0], 128'd0);
        end
        out_ready[0] = 1'b1; key[0] = KEY_C; pt[0] = PT_C; in_valid[0] = 1'b1; #1;
        chk("b2b in_ready", in_ready[0], 128'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        chk("b2b out_valid dropped", out_valid[0], 128'd0);
        wait_ov(0, lat);
        chk("b2b latency", 128'(lat), 128'd10);
        chk("b2b ct", ct[0], CT_C);

        // Back-to-back again, then async reset at rc=7
        key[0] = KEY_B; pt[0] = PT_B; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        repeat (6) @(posedge clk); #1;
        chk("rst rc", g_dut[0].u_dut.rc_q, 128'd7);
        rst_n = 1'b0; #1;
        chk("rst out_valid", out_valid[0], 128'd0);
        chk("rst ct", ct[0], 128'd0);
        chk("rst in_ready", in_ready[0], 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        chk("rst release in_ready", in_ready[0], 128'd1);
        run_vec(0, KEY_B, PT_B, CT_B, 10, "after reset");

        // Abort in BUSY at rc=5
        key[0] = KEY_C; pt[0] = PT_C; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("abort rc", g_dut[0].u_dut.rc_q, 128'd5);
        abort_in[0] = 1'b1;
        @(posedge clk); #1;
        abort_in[0] = 1'b0;
        chk("abort in_ready", in_ready[0], 128'd1);
        chk("abort state", g_dut[0].u_dut.state_q, 128'd0);
        chk("abort rkey", g_dut[0].u_dut.rkey_q, 128'd0);
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            seen = seen | out_valid[0];
        end
        chk("abort no out_valid", seen, 128'd0);
        run_vec(0, KEY_B, PT_B, CT_B, 10, "after abort");

        // Abort in DONE drops the pending ciphertext
        out_ready[0] = 1'b0; key[0] = KEY_C; pt[0] = PT_C; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        wait_ov(0, lat);
        chk("done-abort ct before", ct[0], CT_C);
        abort_in[0] = 1'b1;
        @(posedge clk); #1;
        abort_in[0] = 1'b0;
        chk("done-abort out_valid", out_valid[0], 128'd0);
        chk("done-abort ct", ct[0], 128'd0);

        // Abort wins over a simultaneous accept in IDLE
        in_valid[0] = 1'b1; abort_in[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0; abort_in[0] = 1'b0;
        chk("abort prio in_ready", in_ready[0], 128'd1);
        chk("abort prio rc", g_dut[0].u_dut.rc_q, 128'd0);

`ifdef AES_ROUND_TAP_EN
        out_ready[0] = 1'b1; key[0] = KEY_B; pt[0] = PT_B; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            chk("tap valid", tap_valid[0], 128'd1);
            chk("tap round", tap_round[0], 128'(i));
            if (i == 1) chk("tap state r1", tap_state[0], 128'ha49c7ff2689f352b6b5bea43026a5049);
            if (i == 10) chk("tap state r10", tap_state[0], CT_B);
        end
        @(posedge clk); #1;
        chk("tap valid end", tap_valid[0], 128'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
